// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Covers the fetch FSM state encoding and the PC step and alignment helpers.
package ysyx_23060332_ifu_pkg;

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } fetch_state_e;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

   function automatic logic [31:0] align_pc(input logic [31:0] addr);
      return addr & ALIGN_MASK;
   endfunction

endpackage

// File: rtl/ysyx_23060332_ifu_pc.sv
// PC register for the fetch unit.
// Handles reset load, sequential +4 step, direct redirect, and the deferred (pending) redirect target.
module ysyx_23060332_ifu_pc
   import ysyx_23060332_ifu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_inc,
   input  logic        pc_load,
   input  logic        pend_set,
   input  logic        pend_apply,
   input  logic [31:0] redirect_pc,
   output logic [31:0] pc,
   output logic        pend_valid
);

   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] pend_target_r;
   logic [31:0] pend_target_next_s;
   logic        pend_valid_r;
   logic        pend_valid_next_s;
   logic [31:0] redirect_aligned_s;

   assign redirect_aligned_s = align_pc(redirect_pc);
   assign pc                 = pc_r;
   assign pend_valid         = pend_valid_r;

   // Next PC and pending target; a redirect arriving with the apply wins over the stored target
   always_comb begin
      pc_next_s          = pc_r;
      pend_target_next_s = pend_target_r;
      pend_valid_next_s  = pend_valid_r;
      if (pend_apply) begin
         pc_next_s         = pend_set ? redirect_aligned_s : pend_target_r;
         pend_valid_next_s = 1'b0;
      end else if (pend_set) begin
         pend_target_next_s = redirect_aligned_s;
         pend_valid_next_s  = 1'b1;
      end else if (pc_load) begin
         pc_next_s = redirect_aligned_s;
      end else if (pc_inc) begin
         pc_next_s = pc_r + PC_STEP;
      end else begin
         pc_next_s = pc_r;
      end
   end

   // PC and pending-redirect state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r          <= align_pc(RESET_PC);
         pend_target_r <= 32'd0;
         pend_valid_r  <= 1'b0;
      end else begin
         pc_r          <= pc_next_s;
         pend_target_r <= pend_target_next_s;
         pend_valid_r  <= pend_valid_next_s;
      end
   end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: single-outstanding imem requests, valid/ready delivery to decode,
// redirect and sticky halt handling. The PC and its pending redirect live in ysyx_23060332_ifu_pc.
module ysyx_23060332_ifu
   import ysyx_23060332_ifu_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            imem_rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt,
   output logic            halted
);

   fetch_state_e state_r, state_next_s;
   logic        halt_r, halt_s;
   logic        req_valid_r, halted_r;
   logic        inst_valid_r, inst_err_r;
   logic [31:0] inst_r, inst_pc_r;
   logic [31:0] pc_s;
   logic        pend_valid_s;
   logic        pc_inc_s, pc_load_s, pend_set_s, pend_apply_s;
   logic        inst_load_s, inst_clr_s;

   assign halt_s         = halt | halt_r;
   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_s;
   assign inst_valid     = inst_valid_r;
   assign inst           = inst_r;
   assign inst_pc        = inst_pc_r;
   assign inst_err       = inst_err_r;
   assign halted         = halted_r;

   ysyx_23060332_ifu_pc #(.RESET_PC(RESET_PC)) u_pc (
      .clk         (clk),
      .rst_n       (rst_n),
      .pc_inc      (pc_inc_s),
      .pc_load     (pc_load_s),
      .pend_set    (pend_set_s),
      .pend_apply  (pend_apply_s),
      .redirect_pc (redirect_pc),
      .pc          (pc_s),
      .pend_valid  (pend_valid_s)
   );

   // Fetch FSM next state and PC control; halt always overrides redirect
   always_comb begin
      state_next_s = state_r;
      pc_inc_s     = 1'b0;
      pc_load_s    = 1'b0;
      pend_set_s   = 1'b0;
      pend_apply_s = 1'b0;
      inst_load_s  = 1'b0;
      inst_clr_s   = 1'b0;
      case (state_r)
         REQ: begin
            if (req_valid_r && imem_req_ready) begin
               state_next_s = WAIT;
               pend_set_s   = redirect_valid & ~halt_s;
            end else if (halt_s) begin
               state_next_s = HALT;
            end else begin
               pend_set_s = redirect_valid;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (halt_s) begin
                  state_next_s = HALT;
               end else if (pend_valid_s || redirect_valid) begin
                  pend_apply_s = 1'b1;
                  pend_set_s   = redirect_valid;
                  state_next_s = REQ;
               end else begin
                  inst_load_s  = 1'b1;
                  state_next_s = HOLD;
               end
            end else begin
               pend_set_s = redirect_valid & ~halt_s;
            end
         end
         HOLD: begin
            if (halt_s) begin
               if (inst_ready) begin
                  inst_clr_s   = 1'b1;
                  state_next_s = HALT;
               end else begin
                  state_next_s = HOLD;
               end
            end else if (redirect_valid) begin
               inst_clr_s   = 1'b1;
               pc_load_s    = 1'b1;
               state_next_s = REQ;
            end else if (inst_ready) begin
               inst_clr_s   = 1'b1;
               pc_inc_s     = 1'b1;
               state_next_s = REQ;
            end else begin
               state_next_s = HOLD;
            end
         end
         HALT: begin
            state_next_s = HALT;
         end
         default: begin
            state_next_s = REQ;
         end
      endcase
   end

   // State, registered handshake outputs and the decode-side instruction slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= REQ;
         halt_r       <= 1'b0;
         req_valid_r  <= 1'b0;
         halted_r     <= 1'b0;
         inst_valid_r <= 1'b0;
         inst_r       <= 32'd0;
         inst_pc_r    <= align_pc(RESET_PC);
         inst_err_r   <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         halt_r      <= halt_r | halt;
         req_valid_r <= (state_next_s == REQ);
         halted_r    <= (state_next_s == HALT);
         if (inst_load_s) begin
            inst_valid_r <= 1'b1;
            inst_r       <= imem_rsp_data;
            inst_err_r   <= imem_rsp_err;
            inst_pc_r    <= pc_s;
         end else if (inst_clr_s) begin
            inst_valid_r <= 1'b0;
         end else begin
            inst_valid_r <= inst_valid_r;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Scoreboard bench for ysyx_23060332_ifu: directed stimulus pushes expected requests and
// instructions; a negedge monitor pops and compares at each handshake.
module tb_ysyx_23060332_ifu;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] pc;
      logic        err;
   } exp_inst_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_err;
   logic        inst_valid, inst_ready;
   logic [31:0] inst, inst_pc;
   logic        inst_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt, halted;

   int checks   = 0;
   int failures = 0;

   logic [31:0] req_q[$];
   exp_inst_t   inst_q[$];

   ysyx_23060332_ifu dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .halted         (halted)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   // Monitor: compare every request and instruction handshake against the scoreboard queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (imem_req_valid && imem_req_ready) begin
            if (req_q.size() == 0) begin
               chk("unexpected_req", imem_req_addr, 32'hFFFF_FFFF);
            end else begin
               chk("req_addr", imem_req_addr, req_q.pop_front());
            end
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            if (inst_q.size() == 0) begin
               chk("unexpected_inst", inst, 32'hFFFF_FFFF);
            end else begin
               exp_inst_t e;
               e = inst_q.pop_front();
               chk("inst_data", inst, e.data);
               chk("inst_pc", inst_pc, e.pc);
               chk("inst_err", 32'(inst_err), 32'(e.err));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] exp_addr);
      int n = 0;
      req_q.push_back(exp_addr);
      imem_req_ready = 1'b1;
      while (!imem_req_valid && n < 20) begin
         tick();
         n++;
      end
      if (!imem_req_valid) begin
         void'(req_q.pop_back());
         chk("req_timeout", 32'd0, 32'd1);
         imem_req_ready = 1'b0;
         return;
      end
      tick();
      imem_req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] data, input logic err);
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_err   = err;
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      imem_rsp_err   = 1'b0;
   endtask

   task automatic consume(input logic [31:0] d, input logic [31:0] p, input logic e, input int hold);
      int n = 0;
      while (!inst_valid && n < 20) begin
         tick();
         n++;
      end
      if (!inst_valid) begin
         chk("inst_timeout", 32'd0, 32'd1);
         return;
      end
      inst_q.push_back('{data: d, pc: p, err: e});
      for (int i = 0; i < hold; i++) begin
         chk("hold_inst", inst, d);
         chk("hold_pc", inst_pc, p);
         chk("hold_err", 32'(inst_err), 32'(e));
         chk("hold_no_req", 32'(imem_req_valid), 32'd0);
         tick();
      end
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
   endtask

   task automatic pulse_redirect(input logic [31:0] target, input logic rdy);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      inst_ready     = rdy;
      tick();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'd0;
      imem_rsp_err   = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      halt           = 1'b0;
      repeat (3) tick();
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h8000_0000);
      chk("rst_inst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_inst_pc", inst_pc, 32'h8000_0000);
      chk("rst_inst_err", 32'(inst_err), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      rst_n = 1'b1;

      // basic fetch with 1-cycle response and latency checks
      issue(32'h8000_0000);
      respond(32'h0010_0093, 1'b0);
      chk("lat_inst_valid", 32'(inst_valid), 32'd1);
      consume(32'h0010_0093, 32'h8000_0000, 1'b0, 0);
      chk("lat_next_req", 32'(imem_req_valid), 32'd1);

      // decode stalls 5 cycles
      issue(32'h8000_0004);
      respond(32'h1234_5678, 1'b0);
      consume(32'h1234_5678, 32'h8000_0004, 1'b0, 5);

      // redirect during WAIT discards the response
      issue(32'h8000_0008);
      pulse_redirect(32'h8000_1002, 1'b0);
      tick();
      respond(32'hDEAD_BEEF, 1'b0);
      chk("wait_redir_no_inst", 32'(inst_valid), 32'd0);
      issue(32'h8000_1000);

      // redirect in HOLD with inst_ready high squashes the instruction
      respond(32'h0000_0013, 1'b0);
      chk("hold_valid", 32'(inst_valid), 32'd1);
      pulse_redirect(32'h8000_1000, 1'b1);
      chk("squash_valid", 32'(inst_valid), 32'd0);

      // redirect in REQ with ready low keeps the address until acceptance
      chk("req_pre_addr", imem_req_addr, 32'h8000_1000);
      pulse_redirect(32'h8000_2000, 1'b0);
      for (int i = 0; i < 3; i++) begin
         chk("req_stable_valid", 32'(imem_req_valid), 32'd1);
         chk("req_stable_addr", imem_req_addr, 32'h8000_1000);
         tick();
      end
      issue(32'h8000_1000);
      respond(32'h1111_1111, 1'b0);
      chk("req_redir_no_inst", 32'(inst_valid), 32'd0);
      issue(32'h8000_2000);

      // access fault still delivered, fetch continues
      respond(32'h0000_0000, 1'b1);
      consume(32'h0000_0000, 32'h8000_2000, 1'b1, 0);
      issue(32'h8000_2004);

      // wrap from 0xFFFF_FFFC to 0
      respond(32'h2222_2222, 1'b0);
      pulse_redirect(32'hFFFF_FFFC, 1'b0);
      chk("squash2_valid", 32'(inst_valid), 32'd0);
      issue(32'hFFFF_FFFC);
      respond(32'h3333_3333, 1'b0);
      consume(32'h3333_3333, 32'hFFFF_FFFC, 1'b0, 0);
      issue(32'h0000_0000);

      // halt during WAIT: response discarded, no more requests, redirects ignored
      halt = 1'b1;
      tick();
      halt = 1'b0;
      respond(32'h4444_4444, 1'b0);
      chk("halt_no_inst", 32'(inst_valid), 32'd0);
      chk("halted_set", 32'(halted), 32'd1);
      imem_req_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         pulse_redirect(32'h8000_3000, 1'b0);
         chk("halt_no_req", 32'(imem_req_valid), 32'd0);
         chk("halt_stays", 32'(halted), 32'd1);
      end
      imem_req_ready = 1'b0;

      // reset leaves HALT and fetch restarts at the reset PC
      rst_n = 1'b0;
      #1;
      chk("rst2_halted", 32'(halted), 32'd0);
      chk("rst2_req_addr", imem_req_addr, 32'h8000_0000);
      tick();
      rst_n = 1'b1;
      issue(32'h8000_0000);
      respond(32'h0010_0093, 1'b0);
      consume(32'h0010_0093, 32'h8000_0000, 1'b0, 0);
      tick();

      chk("req_q_empty", 32'(req_q.size()), 32'd0);
      chk("inst_q_empty", 32'(inst_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
